io_out_uart_tx: RTL and testbench
=================================

// Module: io_out_uart_tx
// PURPOSE
//  Responder for the core's output-issue interface (out_issued/out_data/out_stall).
//  Buffers bytes issued by the core in a FIFO and serialises them on a UART TX line (8N1, LSB first).
//  Sits in the I/O module between riscv_pipeline_wrapper and the board UART pin.
//  Drives out_stall back to the core when the buffer cannot accept a byte.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 2
//  FIFO_DEPTH    16   byte entries; power of 2, >= 2
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst          in   1   asynchronous, active-high reset
//  out_issued   in   1   core issues one output byte this cycle
//  out_data     in   32  byte in [7:0]; bits [31:8] ignored
//  out_stall    out  1   1 = FIFO full; issue this cycle not accepted
//  uart_txd     out  1   serial line; idle high
//  tx_busy      out  1   1 = frame in progress or FIFO non-empty
//  tx_count     out  32  total bytes fully transmitted (stop bit completed)
// BEHAVIOUR
//  Reset (async, immediate): uart_txd=1, out_stall=0, tx_busy=0, tx_count=0, FIFO empty,
//   FSM=IDLE. A frame in flight is aborted and queued bytes are discarded.
//  Accept: out_issued & ~out_stall at a rising edge pushes out_data[7:0].
//   out_issued & out_stall: no push, no error. The core holds out_issued/out_data until stall drops.
//  out_stall = (fifo_count == FIFO_DEPTH), derived from registered count; no combinational
//   path from out_issued.
//  Simultaneous push+pop when not full: count unchanged. When full, the push is rejected even if a
//   pop occurs that edge; out_stall drops the following cycle.
//  FSM (bit timer counts 0..CLKS_PER_BIT-1):
//   IDLE : uart_txd=1; FIFO non-empty -> pop head into shift reg, go to START.
//   START: uart_txd=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//   DATA : uart_txd=shift[bit_idx], each bit CLKS_PER_BIT cycles; after bit 7 -> STOP.
//   STOP : uart_txd=1 for CLKS_PER_BIT cycles; at the end tx_count+=1 (wraps 2^32-1 -> 0);
//          FIFO non-empty -> pop and go directly to START (no idle bit); else -> IDLE.
//  Latency: byte pushed into an empty FIFO while idle -> start bit visible 2 cycles after the push edge
//   (1 edge to write, 1 edge to pop/enter START).
//  Frame length: exactly 10*CLKS_PER_BIT cycles; back-to-back frames have no gap.
//  uart_txd is driven from a flop (glitch-free).
//  tx_busy = (state != IDLE) | (fifo_count != 0).
//  FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits wide.
// STRUCTURE
//  io_pkg (shared with the future input/RX block): FSM state encoding (IDLE/START/DATA/STOP),
//   UART_DATA_BITS=8, default CLKS_PER_BIT.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH): push/pop/full/empty/count, async reset,
//   reusable for the RX path.
//  Top level: FSM, bit timer, bit index, shift reg, tx_count.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Single byte: issue 0xA5 while idle -> start bit 2 cycles after push, then bits 1,0,1,0,0,1,0,1,
//     then stop; 40 cycles of frame; tx_count=1; tx_busy falls at stop end.
//  2. Back-to-back: issue 0x00, 0xFF on consecutive cycles -> two frames with no idle gap
//     (80 contiguous cycles); tx_count=2.
//  3. Full/stall: issue 6 bytes 0x01..0x06 holding out_issued under stall -> out_stall high while 4
//     queued; all 6 bytes transmitted in order, none lost or duplicated.
//  4. Push+pop when full: FIFO full and pop at the same edge as an issue -> that push rejected;
//     out_stall=0 next cycle; a held issue is accepted then.
//  5. Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued -> uart_txd=1 immediately;
//     after release: tx_count=0, no frame emitted, out_stall=0.
//  6. Upper bits ignored: out_data=0xDEADBE41 -> serialised byte is 0x41.

Source files
------------

// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the I/O module UART paths (TX now, RX later):
//   uart_state_e          - frame sequencer states
//   UART_DATA_BITS        - data bits per frame (8N1)
//   DEFAULT_CLKS_PER_BIT  - 100 MHz / 115200 baud
//   uart_line_level()     - line level a transmitter drives in a given state
// -----------------------------------------------------------------------------
package io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_BIT_IDX_W       = $clog2(UART_DATA_BITS);
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Idle and stop are marks (1), start is a space (0), data follows the bit.
    function automatic logic uart_line_level(input uart_state_e st, input logic data_bit);
        logic level;
        case (st)
            ST_START: level = 1'b0;
            ST_DATA:  level = data_bit;
            default:  level = 1'b1;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/io_out_uart_tx_if.sv
// -----------------------------------------------------------------------------
// io_out_uart_tx_if
// Core output-issue handshake.
//   out_issued - core issues one output byte this cycle
//   out_data   - byte in [7:0]; [31:8] carried but ignored by the responder
//   out_stall  - responder cannot accept; core holds issued/data until it drops
// master = core side, slave = output responder side.
// -----------------------------------------------------------------------------
interface io_out_uart_tx_if;

    logic        out_issued;
    logic [31:0] out_data;
    logic        out_stall;

    modport master (output out_issued, output out_data, input out_stall);
    modport slave  (input out_issued, input out_data, output out_stall);

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with asynchronous active-high reset, reused by TX and RX.
//   clk, rst  - clock, async reset (empties the FIFO)
//   push, din - write din when push and not full
//   pop, dout - dout shows the head; pop advances it when not empty
//   full, empty, count - occupancy, derived from the registered count
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A push while full is dropped even if a pop happens on the same edge.
    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/io_out_uart_tx.sv
// -----------------------------------------------------------------------------
// io_out_uart_tx
// Buffers bytes issued by the core and sends them as 8N1 UART frames, LSB first.
//   clk, rst   - system clock, asynchronous active-high reset
//   out_if     - core output-issue handshake (slave side); stall = buffer full
//   uart_txd   - serial line, idle high, driven straight from a flop
//   tx_busy    - frame in progress or bytes still queued
//   tx_count   - frames whose stop bit has completed (wraps)
// -----------------------------------------------------------------------------
module io_out_uart_tx
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              rst,
    io_out_uart_tx_if.slave   out_if,
    output logic              uart_txd,
    output logic              tx_busy,
    output logic [31:0]       tx_count
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TIMER_W-1:0]        TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST   = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

    uart_state_e               state_r, state_next_s;
    logic [TIMER_W-1:0]        timer_r, timer_next_s;
    logic [UART_BIT_IDX_W-1:0] bit_idx_r, bit_idx_next_s;
    logic [7:0]                shift_r, shift_next_s;
    logic                      txd_r, txd_next_s;
    logic [31:0]               tx_count_r;
    logic                      count_inc_s;
    logic                      pop_s;
    logic [7:0]                fifo_dout_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic [CNT_W-1:0]          fifo_count_s;
    logic [23:0]               data_unused_s;

    assign data_unused_s = out_if.out_data[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_if.out_issued),
        .din   (out_if.out_data[7:0]),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign out_if.out_stall = fifo_full_s;
    assign uart_txd         = txd_r;
    assign tx_count         = tx_count_r;
    assign tx_busy          = (state_r != ST_IDLE) | (fifo_count_s != CNT_W'(0));

    // Frame sequencer: next state, bit timer, bit index, byte load and pops.
    always_comb begin
        state_next_s   = state_r;
        timer_next_s   = timer_r;
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
        pop_s          = 1'b0;
        count_inc_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_next_s   = TIMER_W'(0);
                bit_idx_next_s = UART_BIT_IDX_W'(0);
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = fifo_dout_s;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_r == TIMER_LAST) begin
                    timer_next_s   = TIMER_W'(0);
                    bit_idx_next_s = UART_BIT_IDX_W'(0);
                    state_next_s   = ST_DATA;
                end else begin
                    timer_next_s = timer_r + TIMER_W'(1);
                end
            end
            ST_DATA: begin
                if (timer_r == TIMER_LAST) begin
                    timer_next_s = TIMER_W'(0);
                    if (bit_idx_r == BIT_LAST) begin
                        state_next_s = ST_STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + UART_BIT_IDX_W'(1);
                    end
                end else begin
                    timer_next_s = timer_r + TIMER_W'(1);
                end
            end
            ST_STOP: begin
                if (timer_r == TIMER_LAST) begin
                    timer_next_s = TIMER_W'(0);
                    count_inc_s  = 1'b1;
                    // Chain straight into the next start bit so queued frames have no gap.
                    if (!fifo_empty_s) begin
                        pop_s          = 1'b1;
                        shift_next_s   = fifo_dout_s;
                        bit_idx_next_s = UART_BIT_IDX_W'(0);
                        state_next_s   = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    timer_next_s = timer_r + TIMER_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                timer_next_s = TIMER_W'(0);
            end
        endcase
        // Line level is computed from the next state so the flop shows it on entry.
        txd_next_s = uart_line_level(state_next_s, shift_next_s[bit_idx_next_s]);
    end

    // Sequencer registers, output line flop and transmitted-frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            timer_r    <= TIMER_W'(0);
            bit_idx_r  <= UART_BIT_IDX_W'(0);
            shift_r    <= 8'd0;
            txd_r      <= 1'b1;
            tx_count_r <= 32'd0;
        end else begin
            state_r   <= state_next_s;
            timer_r   <= timer_next_s;
            bit_idx_r <= bit_idx_next_s;
            shift_r   <= shift_next_s;
            txd_r     <= txd_next_s;
            if (count_inc_s) begin
                tx_count_r <= tx_count_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_io_out_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_io_out_uart_tx
// Directed bench for io_out_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A logger records uart_txd/tx_busy 1 time unit after every rising edge;
// scenarios compare those records and live outputs against hand-built frames.
// -----------------------------------------------------------------------------
module tb_io_out_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int LOGSZ = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_txd;
    logic        tx_busy;
    logic [31:0] tx_count;

    io_out_uart_tx_if bus ();

    io_out_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_if   (bus),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    bit   stall_seen;

    // Line log: entry k holds the outputs just after the k-th rising edge.
    int   log_n = 0;
    logic log_txd  [LOGSZ];
    logic log_busy [LOGSZ];

    always begin
        @(posedge clk);
        #1;
        if (log_n < LOGSZ) begin
            log_txd[log_n]  = uart_txd;
            log_busy[log_n] = tx_busy;
            log_n++;
        end
    end

    logic [7:0] rx_b [16];
    int         rx_n;
    int         rx_ferr;

    // Expected per-cycle line pattern of one frame, index 0 = first start cycle.
    function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
        logic [FRAME-1:0] f;
        int bitn;
        f = '0;
        for (int i = 0; i < FRAME; i++) begin
            bitn = i / CPB;
            if (bitn == 0)      f[i] = 1'b0;
            else if (bitn == 9) f[i] = 1'b1;
            else                f[i] = b[bitn-1];
        end
        return f;
    endfunction

    // Receiver model: mid-bit sampling of the logged line between two indices.
    function automatic void decode(input int from, input int to);
        int i;
        logic [7:0] b;
        rx_n    = 0;
        rx_ferr = 0;
        i       = from;
        while (i + FRAME <= to) begin
            if (log_txd[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = log_txd[i + CPB*(k+1) + CPB/2];
                if (log_txd[i + CPB*9 + CPB/2] !== 1'b1) rx_ferr++;
                if (rx_n < 16) rx_b[rx_n] = b;
                rx_n++;
                i += FRAME;
            end else begin
                i++;
            end
        end
    endfunction

    // Issue one word, holding it while stalled; returns at the negedge after acceptance.
    task automatic push_byte(input logic [31:0] d, output bit ok);
        ok = 1'b0;
        bus.out_issued = 1'b1;
        bus.out_data   = d;
        for (int n = 0; n < 200; n++) begin
            if (bus.out_stall === 1'b0) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            stall_seen = 1'b1;
            @(negedge clk);
        end
        bus.out_issued = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (tx_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_issued = 1'b0;
        bus.out_data   = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({uart_txd, bus.out_stall, tx_busy, tx_count} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL reset_hold: txd/stall/busy/count=%b/%b/%b/%0d want 1/0/0/0",
                     uart_txd, bus.out_stall, tx_busy, tx_count);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({uart_txd, bus.out_stall, tx_busy, tx_count} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL reset_release: txd/stall/busy/count=%b/%b/%b/%0d want 1/0/0/0",
                     uart_txd, bus.out_stall, tx_busy, tx_count);
        end
    endtask

    task automatic test_single();
        int base;
        bit ok;
        logic [FRAME-1:0] obs, exp;
        base = log_n;
        push_byte(32'h0000_00A5, ok);
        repeat (45) @(negedge clk);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL single_accept: accepted=%b want 1", ok);
        end
        checks++;
        if ({log_txd[base], log_txd[base+1]} !== 2'b10) begin
            failures++;
            $display("FAIL single_latency: txd after push edge,+1=%b%b want 10",
                     log_txd[base], log_txd[base+1]);
        end
        for (int i = 0; i < FRAME; i++) obs[i] = log_txd[base + 1 + i];
        exp = frame_bits(8'hA5);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL single_frame: got %h want %h", obs, exp);
        end
        checks++;
        if ({log_busy[base+40], log_busy[base+41], log_txd[base+41]} !== 3'b101) begin
            failures++;
            $display("FAIL single_busy_end: busy@39,40 txd@40=%b%b%b want 101",
                     log_busy[base+40], log_busy[base+41], log_txd[base+41]);
        end
        checks++;
        if (tx_count !== 32'd1) begin
            failures++;
            $display("FAIL single_count: tx_count=%0d want 1", tx_count);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok0, ok1;
        logic [2*FRAME-1:0] obs, exp;
        base = log_n;
        push_byte(32'h0000_0000, ok0);
        push_byte(32'h0000_00FF, ok1);
        repeat (85) @(negedge clk);
        checks++;
        if ({ok0, ok1} !== 2'b11) begin
            failures++;
            $display("FAIL b2b_accept: accepted=%b%b want 11", ok0, ok1);
        end
        for (int i = 0; i < 2*FRAME; i++) obs[i] = log_txd[base + 1 + i];
        exp = {frame_bits(8'hFF), frame_bits(8'h00)};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL b2b_frames: got %h want %h", obs, exp);
        end
        checks++;
        if ({log_busy[base+80], log_busy[base+81]} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_busy_end: busy@79,80=%b%b want 10",
                     log_busy[base+80], log_busy[base+81]);
        end
        checks++;
        if (tx_count !== 32'd3) begin
            failures++;
            $display("FAIL b2b_count: tx_count=%0d want 3", tx_count);
        end
    endtask

    task automatic test_full_stall();
        int base;
        bit ok, all_ok, idle_ok;
        logic [47:0] obs;
        base       = log_n;
        stall_seen = 1'b0;
        all_ok     = 1'b1;
        for (int b = 1; b <= 6; b++) begin
            push_byte(32'(b), ok);
            all_ok &= ok;
            if (b == 5) begin
                checks++;
                if (bus.out_stall !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_full: out_stall=%b with 4 queued want 1", bus.out_stall);
                end
            end
        end
        wait_idle(idle_ok);
        repeat (2) @(negedge clk);
        decode(base, log_n);
        checks++;
        if ({all_ok, stall_seen, idle_ok} !== 3'b111) begin
            failures++;
            $display("FAIL stall_flow: accepted/stall_seen/idle=%b%b%b want 111",
                     all_ok, stall_seen, idle_ok);
        end
        checks++;
        if (rx_n !== 6 || rx_ferr !== 0) begin
            failures++;
            $display("FAIL stall_nframes: frames=%0d framing_err=%0d want 6/0", rx_n, rx_ferr);
        end
        for (int i = 0; i < 6; i++) obs[47 - 8*i -: 8] = rx_b[i];
        checks++;
        if (obs !== 48'h010203040506) begin
            failures++;
            $display("FAIL stall_order: got %h want 010203040506", obs);
        end
        checks++;
        if (tx_count !== 32'd9) begin
            failures++;
            $display("FAIL stall_count: tx_count=%0d want 9", tx_count);
        end
    endtask

    task automatic test_push_pop_full();
        int base;
        bit ok, idle_ok, dropped;
        logic [31:0] c;
        logic [47:0] obs;
        base = log_n;
        for (int b = 8'h11; b <= 8'h15; b++) push_byte(32'(b), ok);
        checks++;
        if (bus.out_stall !== 1'b1) begin
            failures++;
            $display("FAIL ppf_full: out_stall=%b want 1", bus.out_stall);
        end
        c = tx_count;
        bus.out_issued = 1'b1;
        bus.out_data   = 32'h0000_0016;
        dropped = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.out_stall === 1'b0) begin
                dropped = 1'b1;
                break;
            end
        end
        // Stall must drop right after the pop edge, so exactly one more frame completed.
        checks++;
        if ({dropped, tx_count} !== {1'b1, c + 32'd1}) begin
            failures++;
            $display("FAIL ppf_stall_drop: dropped=%b tx_count=%0d want 1/%0d", dropped, tx_count, c + 32'd1);
        end
        @(negedge clk);
        checks++;
        if (bus.out_stall !== 1'b1) begin
            failures++;
            $display("FAIL ppf_held_accept: out_stall=%b after held issue want 1", bus.out_stall);
        end
        bus.out_issued = 1'b0;
        wait_idle(idle_ok);
        repeat (2) @(negedge clk);
        decode(base, log_n);
        for (int i = 0; i < 6; i++) obs[47 - 8*i -: 8] = rx_b[i];
        checks++;
        if (rx_n !== 6 || obs !== 48'h111213141516 || idle_ok !== 1'b1) begin
            failures++;
            $display("FAIL ppf_bytes: frames=%0d bytes=%h idle=%b want 6/111213141516/1", rx_n, obs, idle_ok);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base, bad;
        bit ok;
        push_byte(32'h0000_0052, ok);
        push_byte(32'h0000_0033, ok);
        push_byte(32'h0000_0044, ok);
        // Now one cycle into the start bit; 16 more reaches data bit 3 (0 for 0x52).
        repeat (16) @(negedge clk);
        checks++;
        if ({uart_txd, tx_busy} !== 2'b01) begin
            failures++;
            $display("FAIL rst_pre: txd/busy in bit3=%b%b want 01", uart_txd, tx_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({uart_txd, bus.out_stall, tx_busy, tx_count} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL rst_async: txd/stall/busy/count=%b/%b/%b/%0d want 1/0/0/0",
                     uart_txd, bus.out_stall, tx_busy, tx_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = log_n;
        repeat (50) @(negedge clk);
        bad = 0;
        for (int i = base; i < log_n; i++) if (log_txd[i] !== 1'b1) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rst_no_frame: %0d low line samples after reset want 0", bad);
        end
        checks++;
        if ({bus.out_stall, tx_busy, tx_count} !== {1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL rst_after: stall/busy/count=%b/%b/%0d want 0/0/0",
                     bus.out_stall, tx_busy, tx_count);
        end
    endtask

    task automatic test_upper_bits();
        int base;
        bit ok, idle_ok;
        base = log_n;
        push_byte(32'hDEAD_BE41, ok);
        wait_idle(idle_ok);
        repeat (2) @(negedge clk);
        decode(base, log_n);
        checks++;
        if (rx_n !== 1 || rx_ferr !== 0 || idle_ok !== 1'b1) begin
            failures++;
            $display("FAIL upper_nframes: frames=%0d framing_err=%0d idle=%b want 1/0/1", rx_n, rx_ferr, idle_ok);
        end
        checks++;
        if (rx_b[0] !== 8'h41) begin
            failures++;
            $display("FAIL upper_byte: got %h want 41", rx_b[0]);
        end
        checks++;
        if (tx_count !== 32'd1) begin
            failures++;
            $display("FAIL upper_count: tx_count=%0d want 1", tx_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.out_issued = 1'b0;
        bus.out_data   = 32'd0;
        stall_seen     = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_stall();
        test_push_pop_full();
        test_reset_mid_frame();
        test_upper_bits();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
